// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: redirect input, decode handshake and memory read port.
interface fetch_if;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;
   logic        fetch_fault;
   logic [31:0] mem_address;
   logic [31:0] mem_data_in;
   logic        mem_read_write;
   logic [1:0]  mem_access_size;
   logic        mem_unsigned;

   modport master (
      input  redirect_valid, redirect_pc, inst_ready, mem_data_in,
      output inst_valid, inst_out, inst_pc, fetch_fault,
             mem_address, mem_read_write, mem_access_size, mem_unsigned
   );

   modport slave (
      output redirect_valid, redirect_pc, inst_ready, mem_data_in,
      input  inst_valid, inst_out, inst_pc, fetch_fault,
             mem_address, mem_read_write, mem_access_size, mem_unsigned
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: word fetch from a combinational memory into a small
// prefetch FIFO, presented to decode with its PC; redirect flushes, misaligned target faults.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0100_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic    clock,
   input  logic    reset,
   fetch_if.master bus
);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [31:0] word;
      logic [31:0] pc;
   } entry_t;

   entry_t             fifo_q [FIFO_DEPTH];
   entry_t             head_q, head_n, new_entry;
   logic [PTR_W-1:0]   wr_ptr, wr_n, rd_ptr, rd_n;
   logic [CNT_W-1:0]   count, count_n;
   logic [31:0]        fetch_pc, fetch_pc_n;
   logic               fault, fault_n;
   logic               valid_q, valid_n;
   logic               pop, push;

   // Next-state: redirect beats push/pop; head/valid are precomputed so outputs stay registered.
   always_comb begin
      pop        = valid_q & bus.inst_ready;
      push       = 1'b0;
      wr_n       = wr_ptr;
      rd_n       = rd_ptr;
      count_n    = count;
      fetch_pc_n = fetch_pc;
      fault_n    = fault;
      new_entry  = '{word: bus.mem_data_in, pc: fetch_pc};
      head_n     = '0;

      if (bus.redirect_valid) begin
         wr_n    = '0;
         rd_n    = '0;
         count_n = '0;
         if (bus.redirect_pc[1:0] == 2'b00) begin
            fetch_pc_n = bus.redirect_pc;
            fault_n    = 1'b0;
         end else begin
            fault_n    = 1'b1;
         end
      end else begin
         push = !fault && ((count < CNT_W'(FIFO_DEPTH)) || pop);
         if (push) begin
            wr_n       = wr_ptr + PTR_W'(1);
            fetch_pc_n = fetch_pc + 32'd4;
         end
         if (pop) begin
            rd_n = rd_ptr + PTR_W'(1);
         end
         count_n = count + CNT_W'(push) - CNT_W'(pop);
      end

      valid_n = (count_n != '0);
      if (valid_n) begin
         // The slot being written this cycle can only become head when it is the new entry.
         if (push && (wr_ptr == rd_n)) begin
            head_n = new_entry;
         end else begin
            head_n = fifo_q[rd_n];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         fetch_pc <= RESET_PC;
         fault    <= 1'b0;
         valid_q  <= 1'b0;
         head_q   <= '0;
      end else begin
         wr_ptr   <= wr_n;
         rd_ptr   <= rd_n;
         count    <= count_n;
         fetch_pc <= fetch_pc_n;
         fault    <= fault_n;
         valid_q  <= valid_n;
         head_q   <= head_n;
      end
   end

   // FIFO storage carries no reset; validity is tracked solely by count.
   always_ff @(posedge clock) begin
      if (!reset && push) begin
         fifo_q[wr_ptr] <= new_entry;
      end
   end

   assign bus.inst_valid      = valid_q;
   assign bus.inst_out        = head_q.word;
   assign bus.inst_pc         = head_q.pc;
   assign bus.fetch_fault     = fault;
   assign bus.mem_address     = fetch_pc;
   assign bus.mem_read_write  = 1'b1;
   assign bus.mem_access_size = 2'b10;
   assign bus.mem_unsigned    = 1'b0;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic
// compared against a queue-based model of the fetch stage.
module tb_fetch_unit;
   localparam logic [31:0] RESET_PC = 32'h0100_0000;
   localparam int unsigned DEPTH    = 2;

   logic clock = 1'b0;
   logic reset = 1'b1;
   fetch_if bus();

   fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Memory image: a fixed scramble of the address.
   function automatic logic [31:0] img(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   assign bus.mem_data_in = img(bus.mem_address);

   logic [31:0] m_q [$];
   logic [31:0] m_pc;
   logic        m_fault;
   int unsigned total  = 0;
   int unsigned passed = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // One clock: drive inputs, advance the model, compare every output after the edge.
   task automatic cyc(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
      logic p, ps;
      reset              = rst;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      bus.inst_ready     = rdy;
      if (rst) begin
         m_q.delete();
         m_pc    = RESET_PC;
         m_fault = 1'b0;
      end else begin
         p = (m_q.size() != 0) && rdy;
         if (rv) begin
            m_q.delete();
            if (rpc[1:0] == 2'b00) begin
               m_pc    = rpc;
               m_fault = 1'b0;
            end else begin
               m_fault = 1'b1;
            end
         end else begin
            ps = !m_fault && ((m_q.size() < DEPTH) || p);
            if (p) void'(m_q.pop_front());
            if (ps) begin
               m_q.push_back(m_pc);
               m_pc = m_pc + 32'd4;
            end
         end
      end
      @(posedge clock);
      #1;
      chk("inst_valid", 32'(bus.inst_valid), 32'(m_q.size() != 0));
      chk("inst_pc",    bus.inst_pc,  (m_q.size() != 0) ? m_q[0] : 32'h0);
      chk("inst_out",   bus.inst_out, (m_q.size() != 0) ? img(m_q[0]) : 32'h0);
      chk("mem_address", bus.mem_address, m_pc);
      chk("fetch_fault", 32'(bus.fetch_fault), 32'(m_fault));
      chk("mem_ctrl", {28'h0, bus.mem_read_write, bus.mem_access_size, bus.mem_unsigned}, 32'h0000_000C);
   endtask

   initial begin
      logic        rst_r, rv_r, rdy_r;
      logic [31:0] rpc_r;
      logic [31:0] held;

      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.inst_ready     = 1'b0;

      // Reset state
      cyc(1, 0, 0, 1);
      cyc(1, 0, 0, 1);
      chk("rst_valid", 32'(bus.inst_valid), 32'h0);
      chk("rst_addr", bus.mem_address, RESET_PC);

      // 1: streaming from reset
      cyc(0, 0, 0, 1); chk("t1_pc0", bus.inst_pc, 32'h0100_0000);
      cyc(0, 0, 0, 1); chk("t1_pc1", bus.inst_pc, 32'h0100_0004);
      cyc(0, 0, 0, 1); chk("t1_pc2", bus.inst_pc, 32'h0100_0008);
      cyc(0, 0, 0, 1); chk("t1_pc3", bus.inst_pc, 32'h0100_000C);

      // 2: back-pressure saturates the FIFO, then drains in order
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
      chk("t2_addr_stop", bus.mem_address, 32'h0100_0008);
      chk("t2_head0", bus.inst_pc, 32'h0100_0000);
      cyc(0, 0, 0, 1); chk("t2_head1", bus.inst_pc, 32'h0100_0004);
      cyc(0, 0, 0, 1); chk("t2_head2", bus.inst_pc, 32'h0100_0008);

      // 3: redirect while full with ready high
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 1, 32'h0100_0100, 1);
      chk("t3_valid", 32'(bus.inst_valid), 32'h0);
      chk("t3_addr", bus.mem_address, 32'h0100_0100);
      cyc(0, 0, 0, 1); chk("t3_pc", bus.inst_pc, 32'h0100_0100);

      // 4: misaligned redirect faults, aligned redirect recovers
      held = bus.mem_address;
      cyc(0, 1, 32'h0100_0102, 1);
      chk("t4_fault", 32'(bus.fetch_fault), 32'h1);
      chk("t4_addr_hold", bus.mem_address, held);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      chk("t4_still_invalid", 32'(bus.inst_valid), 32'h0);
      chk("t4_addr_hold2", bus.mem_address, held);
      cyc(0, 1, 32'h0100_0200, 1);
      chk("t4_clear", 32'(bus.fetch_fault), 32'h0);
      cyc(0, 0, 0, 1); chk("t4_pc", bus.inst_pc, 32'h0100_0200);

      // 5: address wrap
      cyc(0, 1, 32'hFFFF_FFFC, 1);
      cyc(0, 0, 0, 1); chk("t5_pc_top", bus.inst_pc, 32'hFFFF_FFFC);
      cyc(0, 0, 0, 1); chk("t5_pc_wrap", bus.inst_pc, 32'h0000_0000);

      // 6: reset mid-stream with two entries held
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 1);
      chk("t6_valid", 32'(bus.inst_valid), 32'h0);
      chk("t6_fault", 32'(bus.fetch_fault), 32'h0);
      chk("t6_addr", bus.mem_address, 32'h0100_0000);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         rst_r = ($urandom_range(63) == 0);
         rv_r  = ($urandom_range(7) == 0);
         rpc_r = $urandom;
         if ($urandom_range(3) != 0) rpc_r[1:0] = 2'b00;
         rdy_r = ($urandom_range(2) != 0);
         cyc(rst_r, rv_r, rpc_r, rdy_r);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
